// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: runtime-programmable clock divider.
// Produces a divided clock (clk_out) and a one-cycle enable strobe (clk_en)
// every div_cur input cycles. New ratios arrive through a valid/ready
// handshake. Ratio changes and stops take effect only on a period boundary,
// so clk_out never shows a runt phase.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   enable     1 = run, 0 = stop at the next period boundary
//   cfg_valid  a ratio is offered on cfg_div
//   cfg_div    requested divide ratio (0 is rejected)
//   cfg_ready  a ratio can be accepted this cycle
//   cfg_err    one-cycle pulse after a zero ratio was accepted and dropped
//   clk_out    divided clock (flop output)
//   clk_en     one strobe per period, in the last cycle (flop output)
//   div_cur    ratio currently in effect
//   running    high in RUN or DRAIN
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | counter stopped, outputs low, ratio writes apply at once
// RUN   | counting
// DRAIN | enable dropped, finishing the current period
module clk_div_ctrl #(
   parameter int CNT_W       = 8,
   parameter int DEFAULT_DIV = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             cfg_valid,
   input  logic [CNT_W-1:0] cfg_div,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic             clk_out,
   output logic             clk_en,
   output logic [CNT_W-1:0] div_cur,
   output logic             running
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] ZERO = '0;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [CNT_W-1:0] div_nxt;
   logic             pend_valid, pend_valid_nxt;
   logic [CNT_W-1:0] pend_div, pend_div_nxt;
   logic             err_nxt;
   logic             clk_out_nxt;
   logic             clk_en_nxt;
   logic             boundary;
   logic             xfer;

   assign cfg_ready = ~pend_valid;
   assign running   = (state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= ZERO;
         div_cur    <= CNT_W'(DEFAULT_DIV);
         pend_valid <= 1'b0;
         pend_div   <= ZERO;
         cfg_err    <= 1'b0;
         clk_out    <= 1'b0;
         clk_en     <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         div_cur    <= div_nxt;
         pend_valid <= pend_valid_nxt;
         pend_div   <= pend_div_nxt;
         cfg_err    <= err_nxt;
         clk_out    <= clk_out_nxt;
         clk_en     <= clk_en_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      div_nxt        = div_cur;
      pend_valid_nxt = pend_valid;
      pend_div_nxt   = pend_div;
      err_nxt        = 1'b0;
      boundary       = (cnt == (div_cur - ONE));
      xfer           = cfg_valid & cfg_ready;

      case (state)
         IDLE: begin
            cnt_nxt = ZERO;
            if (enable) state_nxt = RUN;
         end
         RUN: begin
            if (boundary) begin
               cnt_nxt = ZERO;
               if (!enable) state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt + ONE;
               if (!enable) state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (boundary) begin
               cnt_nxt   = ZERO;
               state_nxt = enable ? RUN : IDLE;
            end else begin
               cnt_nxt = cnt + ONE;
               if (enable) state_nxt = RUN;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = ZERO;
         end
      endcase

      // A pending ratio was latched in an earlier cycle, so applying it at
      // this boundary never uses a value accepted in the boundary itself.
      // In IDLE (reached via a boundary that ended the period) it applies
      // immediately.
      if (pend_valid && (state == IDLE || boundary)) begin
         div_nxt        = pend_div;
         pend_valid_nxt = 1'b0;
      end

      if (xfer) begin
         if (cfg_div == ZERO) begin
            err_nxt = 1'b1;
         end else if (state == IDLE) begin
            div_nxt = cfg_div;
         end else begin
            pend_valid_nxt = 1'b1;
            pend_div_nxt   = cfg_div;
         end
      end

      // Outputs are registered from next-cycle values so each cycle's
      // outputs match that cycle's cnt.
      if (state_nxt == IDLE) begin
         clk_out_nxt = 1'b0;
         clk_en_nxt  = 1'b0;
      end else begin
         clk_out_nxt = (cnt_nxt >= (div_nxt >> 1));
         clk_en_nxt  = (cnt_nxt == (div_nxt - ONE));
      end
   end

endmodule

// File: tb/tb_clk_div_ctrl.sv
module tb_clk_div_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic       cfg_valid;
   logic [7:0] cfg_div;
   logic       cfg_ready;
   logic       cfg_err;
   logic       clk_out;
   logic       clk_en;
   logic [7:0] div_cur;
   logic       running;

   int n_cmp = 0;
   int n_err = 0;

   clk_div_ctrl #(.CNT_W(8), .DEFAULT_DIV(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .cfg_valid (cfg_valid),
      .cfg_div   (cfg_div),
      .cfg_ready (cfg_ready),
      .cfg_err   (cfg_err),
      .clk_out   (clk_out),
      .clk_en    (clk_en),
      .div_cur   (div_cur),
      .running   (running)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // After tick, the outputs shown belong to the new cycle; inputs driven
   // now are sampled at the end of that cycle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; cfg_valid = 1'b0; cfg_div = 8'd0;
      tick(); tick();
      reset = 1'b0;
      chk("rst_running", running, 0);
      chk("rst_clk_out", clk_out, 0);
      chk("rst_clk_en", clk_en, 0);
      chk("rst_cfg_ready", cfg_ready, 1);
      chk("rst_cfg_err", cfg_err, 0);
      chk("rst_div_cur", div_cur, 4);

      // default N=4: clk_out 0,0,1,1 ; clk_en at cnt=3
      enable = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("n4_clk_out", clk_out, ((i % 4) >= 2) ? 1 : 0);
         chk("n4_clk_en", clk_en, ((i % 4) == 3) ? 1 : 0);
         chk("n4_running", running, 1);
      end
      enable = 1'b0;              // dropped in a boundary cycle -> IDLE directly
      tick();
      chk("stop_running", running, 0);
      chk("stop_clk_out", clk_out, 0);

      // IDLE write of 5
      chk("idle_ready", cfg_ready, 1);
      cfg_valid = 1'b1; cfg_div = 8'd5;
      tick();
      cfg_valid = 1'b0;
      chk("idle_div5", div_cur, 5);
      chk("idle_ready_kept", cfg_ready, 1);
      enable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("n5_clk_out", clk_out, ((i % 5) >= 2) ? 1 : 0);
         chk("n5_clk_en", clk_en, ((i % 5) == 4) ? 1 : 0);
      end
      enable = 1'b0;
      tick();
      chk("n5_stop", running, 0);

      // back to 4, change to 2 while running at cnt=1
      cfg_valid = 1'b1; cfg_div = 8'd4;
      tick();
      cfg_valid = 1'b0;
      enable = 1'b1;
      tick();                     // cnt0
      tick();                     // cnt1
      chk("chg_ready_before", cfg_ready, 1);
      cfg_valid = 1'b1; cfg_div = 8'd2;
      tick();                     // cnt2
      cfg_valid = 1'b0;
      chk("chg_ready_low2", cfg_ready, 0);
      chk("chg_div_old", div_cur, 4);
      chk("chg_clk_out2", clk_out, 1);
      tick();                     // cnt3 boundary
      chk("chg_ready_low3", cfg_ready, 0);
      chk("chg_clk_en3", clk_en, 1);
      tick();                     // cnt0 with N=2
      chk("chg_div_new", div_cur, 2);
      chk("chg_clk_out0", clk_out, 0);
      chk("chg_clk_en0", clk_en, 0);
      chk("chg_ready_back", cfg_ready, 1);
      tick();                     // cnt1, boundary of N=2
      chk("n2_clk_out1", clk_out, 1);
      chk("n2_clk_en1", clk_en, 1);

      // write 6 in a boundary cycle: must wait for the following boundary
      cfg_valid = 1'b1; cfg_div = 8'd6;
      tick();                     // cnt0 N=2
      cfg_valid = 1'b0;
      chk("bnd_div_still2", div_cur, 2);
      chk("bnd_ready_low", cfg_ready, 0);
      tick();                     // cnt1 N=2
      chk("bnd_div_still2b", div_cur, 2);
      tick();                     // cnt0 N=6
      chk("bnd_div6", div_cur, 6);
      tick(); tick();             // cnt2
      enable = 1'b0;
      tick();                     // cnt3 DRAIN
      chk("drain_running3", running, 1);
      chk("drain_clk_out3", clk_out, 1);
      chk("drain_clk_en3", clk_en, 0);
      tick();                     // cnt4
      tick();                     // cnt5
      chk("drain_clk_en5", clk_en, 1);
      chk("drain_running5", running, 1);
      tick();                     // IDLE
      chk("drain_idle_running", running, 0);
      chk("drain_idle_clk_out", clk_out, 0);
      chk("drain_idle_clk_en", clk_en, 0);

      // drain then re-enable at cnt=4: no break
      enable = 1'b1;
      tick();                     // cnt0
      tick(); tick();             // cnt2
      enable = 1'b0;
      tick();                     // cnt3 DRAIN
      tick();                     // cnt4
      enable = 1'b1;
      tick();                     // cnt5
      chk("reen_clk_en5", clk_en, 1);
      chk("reen_clk_out5", clk_out, 1);
      tick();                     // cnt0
      chk("reen_running0", running, 1);
      chk("reen_clk_out0", clk_out, 0);
      chk("reen_clk_en0", clk_en, 0);
      tick();                     // cnt1

      // zero ratio rejected while running
      cfg_valid = 1'b1; cfg_div = 8'd0;
      tick();                     // cnt2
      cfg_valid = 1'b0;
      chk("zero_err", cfg_err, 1);
      chk("zero_ready", cfg_ready, 1);
      chk("zero_div", div_cur, 6);
      tick();                     // cnt3
      chk("zero_err_once", cfg_err, 0);
      cfg_valid = 1'b1; cfg_div = 8'd1;
      tick();                     // cnt4
      cfg_valid = 1'b0;
      chk("one_ready_low", cfg_ready, 0);
      tick();                     // cnt5 boundary
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("n1_clk_en", clk_en, 1);
         chk("n1_clk_out", clk_out, 1);
         chk("n1_div", div_cur, 1);
      end

      // reset with a ratio pending
      cfg_valid = 1'b1; cfg_div = 8'd7;
      tick();
      cfg_valid = 1'b0;
      chk("pend_ready_low", cfg_ready, 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      enable = 1'b0;
      chk("rst2_running", running, 0);
      chk("rst2_clk_out", clk_out, 0);
      chk("rst2_clk_en", clk_en, 0);
      chk("rst2_div", div_cur, 4);
      chk("rst2_ready", cfg_ready, 1);
      chk("rst2_err", cfg_err, 0);
      tick();
      chk("rst2_no_pend", div_cur, 4);
      enable = 1'b1;
      tick();                     // cnt0 N=4
      chk("rst2_run_clk_out0", clk_out, 0);
      tick(); tick();             // cnt2
      chk("rst2_run_clk_out2", clk_out, 1);
      chk("rst2_run_div", div_cur, 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
Runtime-programmable clock-divide controller. It produces a divided clock (clk_out) and a one-cycle clock-enable strobe (clk_en) at a ratio of N input cycles. N is set through a valid/ready configuration handshake. Ratio changes and stops take effect only on a period boundary, so clk_out never carries a truncated or runt phase. It sits between the processor/control logic and the slow-domain consumers (display, I/O polling, etc.).

Parameters:
CNT_W, 8, width of the counter and of the divide ratio; legal N is 1..2^CNT_W-1.
DEFAULT_DIV, 4, divide ratio loaded at reset; must be 1..2^CNT_W-1.

Ports:
clk  input  1  system clock; all logic on its rising edge.
reset  input  1  synchronous, active-high reset.
enable  input  1  level; 1 = run the divider, 0 = stop at the next period boundary.
cfg_valid  input  1  a new ratio is offered on cfg_div.
cfg_div  input  CNT_W  requested divide ratio N.
cfg_ready  output  1  controller can accept a ratio this cycle.
cfg_err  output  1  one-cycle pulse: an accepted cfg_div was 0 and was discarded.
clk_out  output  1  divided clock; driven directly from a flop.
clk_en  output  1  one-cycle strobe per period; driven directly from a flop.
div_cur  output  CNT_W  ratio currently in effect.
running  output  1  1 in RUN or DRAIN.

Behaviour:
- Reset values: state IDLE, cnt=0, div_cur=DEFAULT_DIV, no ratio pending, clk_out=0, clk_en=0, cfg_ready=1, cfg_err=0, running=0. Reset has priority over every other event and discards any pending ratio.
- States:
  - IDLE: counter stopped.
  - RUN: counting.
  - DRAIN: enable has dropped; the current period is being finished.
- Counter: cnt runs 0..div_cur-1, then wraps to 0. The cycle in which cnt = div_cur-1 is the boundary cycle.
- Output functions (outputs are registered; in every cycle they equal functions of that cycle's cnt, so compute them from next-state):
  - In RUN/DRAIN: clk_en = (cnt == div_cur-1). clk_out = (cnt >= div_cur>>1). So clk_out is low for floor(N/2) cycles and high for ceil(N/2) cycles.
  - N=1: clk_en=1 and clk_out=1 every cycle.
  - In IDLE: clk_out=0, clk_en=0.
- Transitions:
  - IDLE -> RUN: on the cycle after enable is sampled 1. The first RUN cycle has cnt=0.
  - RUN -> DRAIN: enable sampled 0 in a non-boundary cycle.
  - RUN -> IDLE: enable sampled 0 in a boundary cycle, directly.
  - DRAIN -> IDLE: after the boundary cycle.
  - DRAIN -> RUN: enable sampled 1 again. Counting continues uninterrupted, with no phase change.
- Config handshake: a transfer occurs when cfg_valid & cfg_ready.
  - cfg_div=0: the transfer completes, the value is discarded, and cfg_err pulses the next cycle. No other state changes.
  - In IDLE: div_cur <= cfg_div the next cycle. cfg_ready stays 1.
  - In RUN/DRAIN: the value is latched as pending and cfg_ready drops to 0 the next cycle. At the next boundary cycle (strictly after the accept cycle), div_cur <= pending and cnt <= 0, the pending slot clears, and cfg_ready returns to 1 the following cycle.
  - A transfer that occurs in a boundary cycle is applied at the following boundary, not the current one.
  - A pending ratio is also applied at the boundary that ends DRAIN.
- cfg_valid while cfg_ready=0: no transfer. The requester holds the data.
- div_cur changes only in IDLE or at a boundary. clk_out/clk_en never produce a partial period.
- Reset mid-period: clk_out=0 on the next cycle, regardless of phase.

Test Plan:
- Reset, enable=1, default N=4 -> clk_out pattern 0,0,1,1 repeating; clk_en high on every 4th RUN cycle (cnt=3); running=1.
- In IDLE write cfg_div=5, then enable -> div_cur=5 the next cycle; clk_out 0,0,1,1,1 repeating; clk_en period 5.
- Running N=4, write cfg_div=2 at cnt=1 -> cfg_ready=0 until after the cnt=3 boundary; the cycle after that has cnt=0 with N=2; clk_out 0,1,...; cfg_ready=1 one cycle later.
- Running N=6, drop enable at cnt=2 -> DRAIN, cnt continues 3,4,5; clk_en pulses at cnt=5; then IDLE with clk_out=0, running=0. Repeat, re-raising enable at cnt=4 -> no break in the pattern.
- Write cfg_div=0 in RUN -> cfg_err pulses once, div_cur unchanged, cfg_ready stays 1. Write cfg_div=1 -> clk_en and clk_out held 1 every cycle after the boundary.
- Assert reset mid-period with a ratio pending -> the next cycle shows all reset values, div_cur=DEFAULT_DIV, and the pending ratio is never applied.
